// File: rtl/gpio_input_controller.sv
// gpio_input_controller
// Read-side GPIO port. The external input bus passes through a two-flop
// synchronizer and a whole-bus debounce FSM. The debounced value and a
// ready/overrun status word are readable at two fixed data-memory addresses.
// read_hit steers the core's load mux towards rdata.

module gpio_input_controller #(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DEBOUNCE_CYCLES = 4,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR       = 32'h1001_0028,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR     = 32'h1001_002C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_ram,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] gpio_data_in,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  read_hit,
  output logic                  ready_irq
);

  // One extra bit keeps the counter wide enough to hold DEBOUNCE_CYCLES-1
  // for any legal parameter value, including powers of two.
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   sync1;
  logic [DATA_WIDTH-1:0]   sync2;
  logic [DATA_WIDTH-1:0]   candidate;
  logic [DATA_WIDTH-1:0]   candidate_nxt;
  logic [DATA_WIDTH-1:0]   stable_val;
  logic [DATA_WIDTH-1:0]   stable_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    commit;
  logic                    ready;
  logic                    overrun;
  logic                    data_rd;
  logic                    stat_rd;

  // Two-flop synchronizer on the asynchronous pins; only sync2 feeds logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_data_in;
      sync2 <= sync1;
    end
  end

  // Debounce FSM state register together with its candidate/count/value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      candidate  <= '0;
      cnt        <= '0;
      stable_val <= '0;
    end else begin
      state      <= state_nxt;
      candidate  <= candidate_nxt;
      cnt        <= cnt_nxt;
      stable_val <= stable_nxt;
    end
  end

  // Next-state logic: any bus change restarts the count; a value held for
  // DEBOUNCE_CYCLES consecutive samples commits. Returning to the committed
  // value abandons the attempt.
  always_comb begin
    state_nxt     = state;
    candidate_nxt = candidate;
    cnt_nxt       = cnt;
    stable_nxt    = stable_val;
    commit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync2 != stable_val) begin
          candidate_nxt = sync2;
          cnt_nxt       = CNT_ONE;
          state_nxt     = COUNT;
        end
      end
      COUNT: begin
        if (sync2 == stable_val) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (sync2 != candidate) begin
          candidate_nxt = sync2;
          cnt_nxt       = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          stable_nxt = candidate;
          cnt_nxt    = '0;
          commit     = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address decode and zero-latency read mux; status carries ready at bit 0
  // and overrun at bit 1.
  always_comb begin
    data_rd  = rd_en && (addr_ram == DATA_ADDR);
    stat_rd  = rd_en && (addr_ram == STATUS_ADDR);
    read_hit = data_rd | stat_rd;
    rdata    = '0;
    if (data_rd) begin
      rdata = stable_val;
    end else if (stat_rd) begin
      rdata[0] = ready;
      rdata[1] = overrun;
    end
  end

  // Sticky flags: a commit sets ready and, when the previous value was never
  // read, overrun. A data read in the commit cycle consumes the old value,
  // so it is not an overrun. Sets win over read-side clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (commit) begin
        ready <= 1'b1;
      end else if (data_rd) begin
        ready <= 1'b0;
      end

      if (commit && ready && !data_rd) begin
        overrun <= 1'b1;
      end else if (stat_rd) begin
        overrun <= 1'b0;
      end
    end
  end

  assign ready_irq = ready;

endmodule

// File: tb/tb_gpio_input_controller.sv
// Testbench for gpio_input_controller: directed pin/read scenarios, an
// abstract window-based debounce model checked every cycle, and literal
// expectations at the key points of each scenario.

module tb_gpio_input_controller;

  localparam int          DB      = 4;
  localparam logic [31:0] A_DATA  = 32'h1001_0028;
  localparam logic [31:0] A_STAT  = 32'h1001_002C;
  localparam logic [31:0] A_OTHER = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_ram;
  logic        rd_en;
  logic [7:0]  gpio_data_in;
  logic [7:0]  rdata;
  logic        read_hit;
  logic        ready_irq;

  int vec  = 0;
  int errs = 0;

  gpio_input_controller #(
    .DATA_WIDTH      (8),
    .ADDR_WIDTH      (32),
    .DEBOUNCE_CYCLES (DB),
    .DATA_ADDR       (A_DATA),
    .STATUS_ADDR     (A_STAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_ram     (addr_ram),
    .rd_en        (rd_en),
    .gpio_data_in (gpio_data_in),
    .rdata        (rdata),
    .read_hit     (read_hit),
    .ready_irq    (ready_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pins reach the debouncer two edges late. A value commits once the
  // last DB samples seen by the debouncer are identical and differ from
  // the committed value.
  logic       model_ok = 1'b0;
  logic [7:0] m_s1, m_s2, m_stable, m_samp;
  logic       m_ready, m_ovr, m_all_eq, m_commit, m_drd, m_srd;
  logic [7:0] m_win [DB];

  always @(posedge clk) begin
    if (!reset) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00;
      m_ready = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < DB; i++) m_win[i] = 8'h00;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_samp = m_s2;
      for (int i = DB - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_samp;
      m_all_eq = 1'b1;
      for (int i = 1; i < DB; i++) if (m_win[i] != m_win[0]) m_all_eq = 1'b0;
      m_commit = m_all_eq && (m_win[0] != m_stable);
      m_drd = rd_en && (addr_ram == A_DATA);
      m_srd = rd_en && (addr_ram == A_STAT);
      m_ovr   = (m_commit && m_ready && !m_drd) ? 1'b1 : (m_srd ? 1'b0 : m_ovr);
      m_ready = m_commit ? 1'b1 : (m_drd ? 1'b0 : m_ready);
      if (m_commit) m_stable = m_samp;
      m_s2 = m_s1;
      m_s1 = gpio_data_in;
    end
  end

  logic       e_drd, e_srd;
  logic [7:0] e_rdata;

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      e_drd   = rd_en && (addr_ram == A_DATA);
      e_srd   = rd_en && (addr_ram == A_STAT);
      e_rdata = e_drd ? m_stable : (e_srd ? {6'b0, m_ovr, m_ready} : 8'h00);
      chk("rdata", {24'b0, rdata}, {24'b0, e_rdata});
      chk("read_hit", {31'b0, read_hit}, {31'b0, e_drd | e_srd});
      chk("ready_irq", {31'b0, ready_irq}, {31'b0, m_ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, input logic [7:0] exp, input string name);
    rd_en = 1'b1; addr_ram = a; #1;
    chk(name, {24'b0, rdata}, {24'b0, exp});
    chk({name, "_hit"}, {31'b0, read_hit}, 32'd1);
    rd_en = 1'b0; addr_ram = 32'h0;
  endtask

  initial begin
    reset = 1'b0; rd_en = 1'b0; addr_ram = 32'h0; gpio_data_in = 8'h00;
    cyc(2);
    chk("rst_ready_irq", {31'b0, ready_irq}, 32'd0);
    chk("rst_rdata", {24'b0, rdata}, 32'd0);
    chk("rst_read_hit", {31'b0, read_hit}, 32'd0);

    // Idle after reset; status reads zero, foreign address misses.
    reset = 1'b1;
    cyc(10);
    chk("idle_ready_irq", {31'b0, ready_irq}, 32'd0);
    peek(A_STAT, 8'h00, "idle_status");
    rd_en = 1'b1; addr_ram = A_OTHER; #1;
    chk("other_hit", {31'b0, read_hit}, 32'd0);
    chk("other_rdata", {24'b0, rdata}, 32'd0);
    rd_en = 1'b0; addr_ram = 32'h0;
    cyc(1);

    // 0x00 -> 0xA5: commit exactly at edge 6.
    gpio_data_in = 8'hA5;
    cyc(5);
    chk("a5_edge5", {31'b0, ready_irq}, 32'd0);
    cyc(1);
    chk("a5_edge6", {31'b0, ready_irq}, 32'd1);
    rd_en = 1'b1; addr_ram = A_DATA; #1;
    chk("a5_data", {24'b0, rdata}, 32'hA5);
    cyc(1);
    rd_en = 1'b0; addr_ram = 32'h0;
    chk("a5_ready_cleared", {31'b0, ready_irq}, 32'd0);

    // Back to zero, then a 3-cycle glitch that must not commit.
    gpio_data_in = 8'h00;
    reset = 1'b0; cyc(1); reset = 1'b1; cyc(3);
    gpio_data_in = 8'h01; cyc(3);
    gpio_data_in = 8'h00; cyc(8);
    chk("glitch_ready", {31'b0, ready_irq}, 32'd0);
    peek(A_DATA, 8'h00, "glitch_data");

    // Alternating bounce never commits; settling on 0x03 does.
    for (int i = 0; i < 10; i++) begin
      gpio_data_in = (i % 2 == 0) ? 8'h01 : 8'h03;
      cyc(1);
    end
    chk("bounce_ready", {31'b0, ready_irq}, 32'd0);
    gpio_data_in = 8'h03; cyc(10);
    chk("settle_ready", {31'b0, ready_irq}, 32'd1);
    rd_en = 1'b1; addr_ram = A_DATA; #1;
    chk("settle_data", {24'b0, rdata}, 32'h03);
    cyc(1);
    rd_en = 1'b0; addr_ram = 32'h0;

    // Two unread commits give overrun; a status read clears it.
    gpio_data_in = 8'h11; cyc(8);
    gpio_data_in = 8'h22; cyc(8);
    rd_en = 1'b1; addr_ram = A_STAT; #1;
    chk("ovr_status", {24'b0, rdata}, 32'h03);
    cyc(1);
    chk("ovr_status_next", {24'b0, rdata}, 32'h01);
    addr_ram = A_DATA; #1;
    chk("ovr_data", {24'b0, rdata}, 32'h22);
    cyc(1);
    rd_en = 1'b0; addr_ram = 32'h0;

    // Commit coinciding with a data read while ready is set: no overrun.
    gpio_data_in = 8'h44; cyc(8);
    gpio_data_in = 8'h33; cyc(5);
    rd_en = 1'b1; addr_ram = A_DATA; #1;
    chk("coinc_old_data", {24'b0, rdata}, 32'h44);
    cyc(1);
    rd_en = 1'b0; addr_ram = 32'h0;
    chk("coinc_ready", {31'b0, ready_irq}, 32'd1);
    peek(A_STAT, 8'h01, "coinc_status");
    peek(A_DATA, 8'h33, "coinc_new_data");
    cyc(1);

    // Reset mid-count, then the held 0xFF is debounced afresh.
    gpio_data_in = 8'h00;
    reset = 1'b0; cyc(1); reset = 1'b1; cyc(3);
    gpio_data_in = 8'hFF; cyc(4);
    reset = 1'b0; cyc(1); reset = 1'b1;
    chk("midrst_ready", {31'b0, ready_irq}, 32'd0);
    peek(A_STAT, 8'h00, "midrst_status");
    peek(A_DATA, 8'h00, "midrst_data");
    cyc(5);
    chk("midrst_edge5", {31'b0, ready_irq}, 32'd0);
    cyc(1);
    chk("midrst_edge6", {31'b0, ready_irq}, 32'd1);
    peek(A_DATA, 8'hFF, "midrst_ff");
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/gpio_input_controller.md
# gpio_input_controller

Memory-mapped GPIO input port: the read-side counterpart of the GPIO output register. It samples an 8-bit external input bus (switches/buttons) through a two-flop synchronizer and a per-bus debounce state machine, then holds the debounced value for the MIPS core to read at a fixed data-memory address. A sticky `ready` flag marks unread new data, and an `overrun` flag marks data lost before it was read. Both flags are exposed through a status address. The block drives the read-data mux selector so the core's load path can take `rdata` in place of RAM data.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of `gpio_data_in` and `rdata`.
- `ADDR_WIDTH`, 32: width of `addr_ram`.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to commit; legal values are ≥2.
- `DATA_ADDR`, 32'h10010028: address of the debounced input value.
- `STATUS_ADDR`, 32'h1001002C: address of the status word.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `addr_ram`, input, ADDR_WIDTH: data-memory address from the core.
- `rd_en`, input, 1: core load strobe, valid for one cycle per load.
- `gpio_data_in`, input, DATA_WIDTH: asynchronous external pins.
- `rdata`, output, DATA_WIDTH: read data; 0 when there is no hit.
- `read_hit`, output, 1: demux selector; 1 when the current load targets this block.
- `ready_irq`, output, 1: copy of the `ready` flag, for polling or interrupt use.

## Operation
- Synchronizer: `sync1 <= gpio_data_in`; `sync2 <= sync1`. Only `sync2` is used downstream.
- Debounce FSM registers: `state`, `candidate`, `cnt` (width clog2(DEBOUNCE_CYCLES)+1), and `stable_val`.
- IDLE:
  - If `sync2 != stable_val`: `candidate <= sync2`, `cnt <= 1`, go to COUNT.
  - Otherwise stay in IDLE.
- COUNT, with conditions checked in this order:
  - If `sync2 == stable_val`: `cnt <= 0`, go to IDLE (the bounce returned to the old value).
  - Else if `sync2 != candidate`: `candidate <= sync2`, `cnt <= 1`, stay in COUNT.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: commit. `stable_val <= candidate`, `cnt <= 0`, go to IDLE.
  - Else `cnt <= cnt+1`.
- Whole-bus debounce: any bit changing restarts the count. A commit always carries a value different from the old `stable_val`.
- Hit decode (combinational):
  - `data_rd = rd_en && addr_ram == DATA_ADDR`.
  - `stat_rd = rd_en && addr_ram == STATUS_ADDR`.
  - `read_hit = data_rd | stat_rd`.
- `rdata` (combinational):
  - On `data_rd`: `stable_val`.
  - On `stat_rd`: `{zeros, overrun, ready}`, with `ready` at bit 0 and `overrun` at bit 1.
  - Otherwise 0.
- `ready` update:
  - Set on commit.
  - Else cleared on `data_rd`.
  - Set wins over clear in the same cycle.
- `overrun` update:
  - Set on `commit && ready && !data_rd`.
  - Else cleared on `stat_rd`.
  - Set wins over clear in the same cycle.
  - A commit in the same cycle as a data read is not an overrun, because the old value was consumed.
- Writes to either address are ignored; the block has no write port.
- Reset (`reset == 0` at a rising edge) clears all of the following, including mid-count:
  - `sync1`, `sync2`, `candidate`, `stable_val`: 0.
  - `cnt`: 0.
  - `state`: IDLE.
  - `ready`, `overrun`: 0.
- After reset, any nonzero level held on the pins is debounced and committed like a normal change.

## Timing
- Reset values of outputs: `rdata = 0`, `read_hit = 0`, `ready_irq = 0`. `read_hit` and `rdata` stay combinational from `rd_en`/`addr_ram` during reset; register-derived fields read 0.
- Commit latency: the pins change and then hold stable. Counting the first rising edge that samples the new value as edge 1, `stable_val` and `ready` update at edge DEBOUNCE_CYCLES+2 (edge 6 with the default).
- A glitch held for at most DEBOUNCE_CYCLES-1 `sync2` cycles never commits.
- Read latency: zero cycles. `rdata` and `read_hit` are valid in the same cycle as `rd_en`/`addr_ram`.
- Flag clears from a read take effect at the rising edge ending the read cycle. A status read therefore returns the pre-clear `overrun` value.
- `ready_irq` follows `ready` with no additional delay.

## Test plan
- Reset with pins = 0, then hold `reset` high for 10 cycles → `ready_irq = 0`. A read of `STATUS_ADDR` returns 0x00 with `read_hit = 1`. A load to 0x10010000 gives `read_hit = 0`, `rdata = 0`.
- Pins 0x00→0xA5 held, DEBOUNCE_CYCLES = 4 → `ready_irq` rises after edge 6, not earlier. A `DATA_ADDR` read returns 0xA5, and `ready_irq = 0` after that edge.
- Pins pulse 0x00→0x01 for 3 cycles then return to 0x00 → no commit, `ready_irq` stays 0, `DATA_ADDR` reads 0x00. Repeat with bounce 0x01/0x03 alternating each cycle → no commit until stable.
- Two commits (0x11, then 0x22) with no read between them → status reads 0x03. Next cycle status reads 0x01, and `DATA_ADDR` returns 0x22.
- Commit edge coincides with a `DATA_ADDR` read → the read returns the old value, `ready` stays 1, `overrun` stays 0.
- Pins 0x00→0xFF, `reset` asserted at count 2 for 1 cycle → all flags 0, `DATA_ADDR` reads 0x00. `ready_irq` rises DEBOUNCE_CYCLES+2 edges after release and reads 0xFF.
